// File: rtl/bsg_fifo_1r1w_small_width_p4_els_p4.sv
// bsg_fifo_1r1w_small_width_p4_els_p4
// Small first-word-fall-through FIFO between a valid/ready producer and a
// valid/yumi consumer. Circular buffer with wrap-bit pointers.
// Optional feature: define BSG_FIFO_COUNT_EN to add the count_o occupancy port.
module bsg_fifo_1r1w_small_width_p4_els_p4 #(
  parameter int width_p = 4,
  parameter int els_p   = 4
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               v_i,
  input  logic [width_p-1:0] data_i,
  output logic               ready_o,
  output logic               v_o,
  output logic [width_p-1:0] data_o,
  input  logic               yumi_i
`ifdef BSG_FIFO_COUNT_EN
  ,
  output logic [$clog2(els_p+1)-1:0] count_o
`endif
);

  localparam int IDX_W = $clog2(els_p);
  localparam int PTR_W = IDX_W + 1;

  // Storage is deliberately left unreset; the pointers alone define validity.
  logic [width_p-1:0] mem_q [els_p];

  logic [PTR_W-1:0] wptr_q, wptr_d;
  logic [PTR_W-1:0] rptr_q, rptr_d;

  logic full;
  logic empty;
  logic enq;
  logic deq;

  // Same index with opposite wrap bits means the writer is a full lap ahead.
  assign empty = (wptr_q == rptr_q);
  assign full  = (wptr_q[IDX_W-1:0] == rptr_q[IDX_W-1:0]) &&
                 (wptr_q[IDX_W] != rptr_q[IDX_W]);

  // Handshakes are gated by the registered flags, so a push into a full FIFO
  // or a yumi on an empty FIFO has no effect, and no input reaches an output.
  assign enq = v_i & ~full;
  assign deq = yumi_i & ~empty;

  assign ready_o = ~full;
  assign v_o     = ~empty;
  assign data_o  = mem_q[rptr_q[IDX_W-1:0]];

  // Next-state pointers: advance by one on a handshake, wrapping naturally.
  always_comb begin
    wptr_d = wptr_q + PTR_W'(enq);
    rptr_d = rptr_q + PTR_W'(deq);
  end

  // Pointer registers; asynchronous reset empties the FIFO immediately.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  // Write the accepted word into the slot addressed by the write index.
  always_ff @(posedge clk_i) begin
    if (enq) begin
      mem_q[wptr_q[IDX_W-1:0]] <= data_i;
    end
  end

`ifdef BSG_FIFO_COUNT_EN
  localparam int CNT_W = $clog2(els_p + 1);

  // Modular pointer difference gives 0..els_p directly from registered state.
  logic [PTR_W-1:0] occ;
  assign occ     = wptr_q - rptr_q;
  assign count_o = CNT_W'(occ);
`endif

endmodule

// File: tb/tb_bsg_fifo_1r1w_small_width_p4_els_p4.sv
// Directed self-checking bench for bsg_fifo_1r1w_small_width_p4_els_p4.
// Occupancy checks on count_o are compiled in when BSG_FIFO_COUNT_EN is defined.
module tb_bsg_fifo_1r1w_small_width_p4_els_p4;

  logic       clk_i;
  logic       reset_i;
  logic       v_i;
  logic [3:0] data_i;
  logic       ready_o;
  logic       v_o;
  logic [3:0] data_o;
  logic       yumi_i;
`ifdef BSG_FIFO_COUNT_EN
  logic [2:0] count_o;
`endif

  int errors;
  int checks;

  bsg_fifo_1r1w_small_width_p4_els_p4 #(.width_p(4), .els_p(4)) dut (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .v_i     (v_i),
    .data_i  (data_i),
    .ready_o (ready_o),
    .v_o     (v_o),
    .data_o  (data_o),
    .yumi_i  (yumi_i)
`ifdef BSG_FIFO_COUNT_EN
    ,
    .count_o (count_o)
`endif
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // Advance to 1 time unit after the next rising edge.
  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic test_reset();
    reset_i = 1'b0;
    v_i     = 1'b0;
    yumi_i  = 1'b0;
    data_i  = 4'h0;
    step();
    #3;
    reset_i = 1'b1;
    #1;
    checks++;
    if (ready_o !== 1'b1) begin
      errors++; $display("FAIL reset_ready: got %b want 1", ready_o);
    end
    checks++;
    if (v_o !== 1'b0) begin
      errors++; $display("FAIL reset_v: got %b want 0", v_o);
    end
`ifdef BSG_FIFO_COUNT_EN
    checks++;
    if (count_o !== 3'd0) begin
      errors++; $display("FAIL reset_count: got %0d want 0", count_o);
    end
`endif
    step();
    #2;
    reset_i = 1'b0;
    step();
  endtask

  task automatic test_fill_drain();
    for (int i = 1; i <= 4; i++) begin
      v_i    = 1'b1;
      data_i = 4'(i);
      step();
      checks++;
      if (v_o !== 1'b1 || data_o !== 4'h1) begin
        errors++; $display("FAIL fill_head_%0d: got v=%b d=%h want v=1 d=1", i, v_o, data_o);
      end
    end
    checks++;
    if (ready_o !== 1'b0) begin
      errors++; $display("FAIL fill_full_ready: got %b want 0", ready_o);
    end
`ifdef BSG_FIFO_COUNT_EN
    checks++;
    if (count_o !== 3'd4) begin
      errors++; $display("FAIL fill_count: got %0d want 4", count_o);
    end
`endif
    // Extra push while full must be dropped.
    data_i = 4'hF;
    step();
    checks++;
    if (ready_o !== 1'b0 || data_o !== 4'h1) begin
      errors++; $display("FAIL full_push_ignored: got rdy=%b d=%h want rdy=0 d=1", ready_o, data_o);
    end
`ifdef BSG_FIFO_COUNT_EN
    checks++;
    if (count_o !== 3'd4) begin
      errors++; $display("FAIL full_push_count: got %0d want 4", count_o);
    end
`endif
    v_i    = 1'b0;
    yumi_i = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      checks++;
      if (v_o !== 1'b1 || data_o !== 4'(i)) begin
        errors++; $display("FAIL drain_%0d: got v=%b d=%h want v=1 d=%h", i, v_o, data_o, 4'(i));
      end
      step();
    end
    yumi_i = 1'b0;
    checks++;
    if (v_o !== 1'b0 || ready_o !== 1'b1) begin
      errors++; $display("FAIL drain_empty: got v=%b rdy=%b want v=0 rdy=1", v_o, ready_o);
    end
  endtask

  task automatic test_streaming_wrap();
    int outidx;
    outidx = 0;
    v_i = 1'b1;
    for (int k = 0; k < 20; k++) begin
      data_i = 4'(k);
      yumi_i = v_o;
      if (v_o === 1'b1) begin
        checks++;
        if (data_o !== 4'(outidx)) begin
          errors++; $display("FAIL stream_out_%0d: got %h want %h", outidx, data_o, 4'(outidx));
        end
        outidx++;
      end
      checks++;
      if (ready_o !== 1'b1) begin
        errors++; $display("FAIL stream_ready_%0d: got %b want 1", k, ready_o);
      end
`ifdef BSG_FIFO_COUNT_EN
      checks++;
      if (count_o > 3'd1) begin
        errors++; $display("FAIL stream_occ_%0d: got %0d want <=1", k, count_o);
      end
`endif
      step();
    end
    v_i    = 1'b0;
    yumi_i = 1'b1;
    checks++;
    if (v_o !== 1'b1 || data_o !== 4'h3) begin
      errors++; $display("FAIL stream_last: got v=%b d=%h want v=1 d=3", v_o, data_o);
    end
    step();
    yumi_i = 1'b0;
    outidx++;
    checks++;
    if (v_o !== 1'b0 || outidx != 20) begin
      errors++; $display("FAIL stream_end: got v=%b n=%0d want v=0 n=20", v_o, outidx);
    end
  endtask

  task automatic test_full_simultaneous();
    v_i = 1'b1;
    for (int i = 6; i <= 9; i++) begin
      data_i = 4'(i);
      step();
    end
    checks++;
    if (ready_o !== 1'b0) begin
      errors++; $display("FAIL simul_prefull: got rdy=%b want 0", ready_o);
    end
    data_i = 4'hA;
    yumi_i = 1'b1;
    step();
    v_i = 1'b0;
    checks++;
    if (ready_o !== 1'b1 || data_o !== 4'h7) begin
      errors++; $display("FAIL simul_after: got rdy=%b d=%h want rdy=1 d=7", ready_o, data_o);
    end
`ifdef BSG_FIFO_COUNT_EN
    checks++;
    if (count_o !== 3'd3) begin
      errors++; $display("FAIL simul_count: got %0d want 3", count_o);
    end
`endif
    for (int i = 7; i <= 9; i++) begin
      checks++;
      if (v_o !== 1'b1 || data_o !== 4'(i)) begin
        errors++; $display("FAIL simul_drain_%0d: got v=%b d=%h want v=1 d=%h", i, v_o, data_o, 4'(i));
      end
      step();
    end
    yumi_i = 1'b0;
    checks++;
    if (v_o !== 1'b0) begin
      errors++; $display("FAIL simul_no_A: got v=%b d=%h want v=0", v_o, data_o);
    end
  endtask

  task automatic test_illegal_yumi();
    v_i    = 1'b0;
    yumi_i = 1'b1;
    step();
    step();
    yumi_i = 1'b0;
    checks++;
    if (v_o !== 1'b0 || ready_o !== 1'b1) begin
      errors++; $display("FAIL illegal_yumi_state: got v=%b rdy=%b want v=0 rdy=1", v_o, ready_o);
    end
`ifdef BSG_FIFO_COUNT_EN
    checks++;
    if (count_o !== 3'd0) begin
      errors++; $display("FAIL illegal_yumi_count: got %0d want 0", count_o);
    end
`endif
    v_i    = 1'b1;
    data_i = 4'h5;
    step();
    v_i = 1'b0;
    checks++;
    if (v_o !== 1'b1 || data_o !== 4'h5) begin
      errors++; $display("FAIL illegal_yumi_enq: got v=%b d=%h want v=1 d=5", v_o, data_o);
    end
    yumi_i = 1'b1;
    step();
    yumi_i = 1'b0;
    checks++;
    if (v_o !== 1'b0) begin
      errors++; $display("FAIL illegal_yumi_drain: got v=%b want 0", v_o);
    end
  endtask

  task automatic test_mid_reset();
    v_i = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      data_i = 4'(i);
      step();
    end
    v_i = 1'b0;
    checks++;
    if (v_o !== 1'b1) begin
      errors++; $display("FAIL midrst_pre: got v=%b want 1", v_o);
    end
    #3;
    reset_i = 1'b1;
    #1;
    checks++;
    if (v_o !== 1'b0 || ready_o !== 1'b1) begin
      errors++; $display("FAIL midrst_immediate: got v=%b rdy=%b want v=0 rdy=1", v_o, ready_o);
    end
`ifdef BSG_FIFO_COUNT_EN
    checks++;
    if (count_o !== 3'd0) begin
      errors++; $display("FAIL midrst_count: got %0d want 0", count_o);
    end
`endif
    #1;
    reset_i = 1'b0;
    step();
    v_i    = 1'b1;
    data_i = 4'h9;
    step();
    v_i = 1'b0;
    checks++;
    if (v_o !== 1'b1 || data_o !== 4'h9) begin
      errors++; $display("FAIL midrst_head: got v=%b d=%h want v=1 d=9", v_o, data_o);
    end
`ifdef BSG_FIFO_COUNT_EN
    checks++;
    if (count_o !== 3'd1) begin
      errors++; $display("FAIL midrst_head_count: got %0d want 1", count_o);
    end
`endif
    yumi_i = 1'b1;
    step();
    yumi_i = 1'b0;
    checks++;
    if (v_o !== 1'b0) begin
      errors++; $display("FAIL midrst_drain: got v=%b want 0", v_o);
    end
  endtask

  initial begin
    errors  = 0;
    checks  = 0;
    reset_i = 1'b0;
    v_i     = 1'b0;
    yumi_i  = 1'b0;
    data_i  = 4'h0;
    test_reset();
    test_fill_drain();
    test_streaming_wrap();
    test_full_simultaneous();
    test_illegal_yumi();
    test_mid_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
